// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Watches a multiplexed, active-low seven-segment display bus and turns it
// back into hex digits. Each {an, seg} pattern must be held unchanged for
// STABLE_CYCLES consecutive sampling edges before it is acted on, so short
// glitches during the scan are ignored. Decoded digits are placed into their
// slot of a frame word. A frame pulse is raised once every slot has been
// written since the previous frame.

module seg7_scan_decoder #(
    parameter  int NUM_DIGITS    = 4,
    parameter  int STABLE_CYCLES = 4,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    leda,
    input  logic                    ledb,
    input  logic                    ledc,
    input  logic                    ledd,
    input  logic                    lede,
    input  logic                    ledf,
    input  logic                    ledg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [3:0]              nibble,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    nibble_valid,
    output logic                    seg_error,
    output logic                    an_error,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    frame_valid
);

    localparam int         SAMPLE_W = NUM_DIGITS + 7;
    localparam logic [7:0] STABLE   = 8'(STABLE_CYCLES);

    logic [6:0]            seg;
    logic [SAMPLE_W-1:0]   sample;
    logic [SAMPLE_W-1:0]   s1;
    logic [7:0]            cnt;
    logic                  capture;
    logic [NUM_DIGITS-1:0] digit_valid;

    logic                  code_hit;
    logic [3:0]            code;
    logic [NUM_DIGITS-1:0] an_low;
    logic                  an_blank;
    logic                  an_single;
    logic [IDX_W-1:0]      an_index;

    assign seg    = {leda, ledb, ledc, ledd, lede, ledf, ledg};
    assign sample = {an, seg};

    // The pattern has been seen STABLE_CYCLES times already; this edge is the
    // one where cnt reaches STABLE_CYCLES, which is the only capture moment.
    assign capture = (sample == s1) && (cnt == STABLE - 8'd1);

    // Register the raw bus and count how long it has stayed unchanged; the
    // count saturates so a held pattern is captured only once.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1  <= '1;
            cnt <= '0;
        end else begin
            s1 <= sample;
            if (sample != s1) begin
                cnt <= '0;
            end else if (cnt != STABLE) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Map an active-low segment pattern back to the hex digit it encodes.
    always_comb begin
        code_hit = 1'b1;
        code     = 4'h0;
        case (seg)
            7'b0000001: code = 4'h0;
            7'b1001111: code = 4'h1;
            7'b0010010: code = 4'h2;
            7'b0000110: code = 4'h3;
            7'b1001100: code = 4'h4;
            7'b0100100: code = 4'h5;
            7'b0100000: code = 4'h6;
            7'b0001111: code = 4'h7;
            7'b0000000: code = 4'h8;
            7'b0000100: code = 4'h9;
            7'b0001000: code = 4'hA;
            7'b1100000: code = 4'hB;
            7'b0110001: code = 4'hC;
            7'b1000010: code = 4'hD;
            7'b0110000: code = 4'hE;
            7'b0111000: code = 4'hF;
            default:    code_hit = 1'b0;
        endcase
    end

    // Classify the digit enables as blank, a single active digit, or an
    // illegal multi-digit selection, and find the active slot.
    always_comb begin
        an_low    = ~an;
        an_blank  = (an_low == '0);
        an_single = !an_blank && ((an_low & (an_low - 1'b1)) == '0);
        an_index  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_low[i]) begin
                an_index = IDX_W'(i);
            end
        end
    end

    // Act on captured patterns and retire complete frames one edge later;
    // the two never coincide because captures are spaced further apart.
    always_ff @(posedge clock) begin
        if (reset) begin
            nibble       <= '0;
            digit_idx    <= '0;
            value        <= '0;
            digit_valid  <= '0;
            nibble_valid <= 1'b0;
            seg_error    <= 1'b0;
            an_error     <= 1'b0;
            frame_valid  <= 1'b0;
        end else begin
            nibble_valid <= 1'b0;
            seg_error    <= 1'b0;
            an_error     <= 1'b0;
            frame_valid  <= 1'b0;

            if (&digit_valid) begin
                frame_valid <= 1'b1;
                digit_valid <= '0;
            end

            if (capture && !an_blank) begin
                if (!an_single) begin
                    an_error <= 1'b1;
                end else if (!code_hit) begin
                    seg_error <= 1'b1;
                end else begin
                    nibble       <= code;
                    digit_idx    <= an_index;
                    nibble_valid <= 1'b1;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (an_low[i]) begin
                            value[4*i +: 4] <= code;
                            digit_valid[i]  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reads the multiplexed seven-segment interface driven by the team's hex-to-segment encoder and reconstructs the hexadecimal digits it displays.
- Samples the segment lines together with the active-low digit enables.
- Filters glitches with a stability counter.
- Decodes each stable pattern to a nibble and assembles a full multi-digit value per scan frame.
- Used for loopback self-check of display paths and as a bench monitor.

Parameters:
- NUM_DIGITS, 4: number of scanned digits; an width; value width is 4*NUM_DIGITS.
- STABLE_CYCLES, 4: consecutive matching samples required before capture; legal range 2..255.

Ports:
- clock  input  1  system clock; all inputs are synchronous to it.
- reset  input  1  synchronous, active-high.
- leda..ledg  input  1 each  segment lines, active-low (0 = lit); pattern word seg = {leda,ledb,ledc,ledd,lede,ledf,ledg}.
- an  input  NUM_DIGITS  digit enables, active-low, one-hot-low; all ones = blank.
- nibble  output  4  last decoded digit value.
- digit_idx  output  $clog2(NUM_DIGITS) (min 1)  slot of last decoded digit.
- nibble_valid  output  1  one-cycle pulse, nibble/digit_idx updated.
- seg_error  output  1  one-cycle pulse, stable pattern not in code table.
- an_error  output  1  one-cycle pulse, stable an has more than one zero.
- value  output  4*NUM_DIGITS  assembled frame; digit i at [4i+3:4i].
- frame_valid  output  1  one-cycle pulse, every slot written since last frame.

Behaviour:
- Reset values:
  - s1 (sampled {an,seg}) = all ones.
  - cnt = 0.
  - nibble = 0, digit_idx = 0, value = 0, digit_valid[NUM_DIGITS-1:0] = 0.
  - All pulse outputs = 0.
- Reset mid-frame discards partial frame contents.
- Sampling and stability, every edge:
  - s1 <= {an,seg}.
  - If {an,seg} != s1, then cnt <= 0.
  - Else if cnt != STABLE_CYCLES, then cnt <= cnt+1.
  - cnt saturates; no recapture while the pattern is held.
- Capture event: at the edge where cnt becomes STABLE_CYCLES.
  - A pattern first seen at edge E0 and held captures at edge E(STABLE_CYCLES).
  - Outputs are registered there, so pulses are high in the cycle after E(STABLE_CYCLES).
  - With the default, this is 5 consecutive sampling edges.
- On capture, by an class:
  - an all ones: no action (blank interval).
  - an with exactly one zero at bit i: decode seg per the table below.
    - Hit: nibble <= code, digit_idx <= i, value slot i <= code, digit_valid[i] <= 1, nibble_valid pulse.
    - Miss: seg_error pulse; value and digit_valid unchanged.
  - an with two or more zeros: an_error pulse only; seg is not decoded.
- Code table (seg -> nibble):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3
  - 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0000100->9, 0001000->A, 1100000->B
  - 0110001->C, 1000010->D, 0110000->E, 0111000->F
  - All other 112 patterns are errors.
- Overwrite: recapturing an already-valid slot replaces its nibble; digit_valid stays 1.
- Frame completion:
  - frame_valid is registered and pulses the cycle after the capture that makes digit_valid all ones.
  - In that same edge digit_valid clears to 0; value holds the full frame and is not cleared.
- Simultaneity:
  - Captures are at least STABLE_CYCLES+1 edges apart (STABLE_CYCLES >= 2), so no capture coincides with the frame_valid/clear edge.
  - nibble_valid, seg_error and an_error are mutually exclusive.
- Reset dominates all other updates in the same edge.

Test Plan:
- Reset, then an=1110 with seg=0000110 held 5 edges -> nibble_valid one cycle after 5th edge; nibble=3, digit_idx=0; value[3:0]=3; no further pulse while held.
- an=1110 seg=1001111 held only 3 edges, then blank -> no nibble_valid, value unchanged.
- an=1101 seg=1111111 held 5 edges -> seg_error single pulse; digit_valid[1] stays 0.
- an=1100 any seg held 5 edges -> an_error single pulse; no decode.
- Scan digits 0..3 with 4,3,2,1, each held 6 edges with 2 blank edges between -> four nibble_valid pulses; frame_valid one cycle after last with value=16'h1234; digit_valid then 0.
- Capture digits 0 and 1, assert reset one cycle, then capture digits 2 and 3 -> no frame_valid; value shows only slots 2,3 written, slots 0,1 = 0.
